// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the RISCV32I byte-bus memory controller: widths,
// access-size codes and the controller state encoding.
package mem_ctrl_pkg;

    localparam int ADDR_LEN = 32;
    localparam int INST_LEN = 32;
    localparam int REG_LEN  = 32;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IF_RD,
        ST_MEM_RD,
        ST_MEM_WR
    } state_t;

    // Reserved size code 2'b11 falls through to a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester and byte-bus signals of the memory controller. The slave modport
// is the controller itself; master is the surrounding core plus RAM/IO bus.
interface mem_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_LEN,
    parameter int DATA_W = REG_LEN
);
    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic                if_flush;
    logic                if_done;
    logic [INST_LEN-1:0] if_inst;

    logic                mem_req;
    logic                mem_we;
    logic [1:0]          mem_size;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_done;
    logic [DATA_W-1:0]   mem_rdata;

    logic [7:0]          ram_din;
    logic [7:0]          ram_dout;
    logic [ADDR_W-1:0]   ram_a;
    logic                ram_wr;

    modport master (
        output if_req, if_addr, if_flush,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output ram_din,
        input  if_done, if_inst, mem_done, mem_rdata,
        input  ram_dout, ram_a, ram_wr
    );

    modport slave (
        input  if_req, if_addr, if_flush,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  ram_din,
        output if_done, if_inst, mem_done, mem_rdata,
        output ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetch and MEM-stage accesses onto the single byte-wide
// RAM/IO bus, serialising 1/2/4-byte transfers and reassembling read words.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_LEN,
    parameter int DATA_W = REG_LEN
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    mem_ctrl_if.slave bus
);

    state_t            state;
    logic [2:0]        iss_cnt;
    logic [2:0]        rcv_cnt;
    logic [2:0]        n_q;
    logic              wr_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rbuf_q;
    logic [DATA_W-1:0] rd_word;
    logic              can_accept;
    logic              accept_mem;
    logic              accept_if;
    logic              flush_rd;
    logic              capture;
    logic              last_rcv;

    function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] word,
                                                   input logic [1:0]        lane,
                                                   input logic [7:0]        data);
        logic [DATA_W-1:0] res;
        res = word;
        res[8*lane +: 8] = data;
        return res;
    endfunction

    // The done cycle is spent in IDLE, but nothing new is sampled until it has passed.
    assign can_accept = (state == ST_IDLE) && !bus.if_done && !bus.mem_done;
    assign accept_mem = can_accept && bus.mem_req;
    assign accept_if  = can_accept && !bus.mem_req && bus.if_req && !bus.if_flush;
    assign flush_rd   = (state == ST_IF_RD) && bus.if_flush;

    // Byte k arrives one cycle after its address, i.e. once two addresses are out.
    assign capture  = ((state == ST_IF_RD) || (state == ST_MEM_RD)) && !flush_rd
                      && (iss_cnt >= 3'd2);
    assign last_rcv = capture && (rcv_cnt == n_q - 3'd1);
    assign rd_word  = put_byte(rbuf_q, rcv_cnt[1:0], bus.ram_din);

    assign bus.ram_wr = wr_q & rdy_in;

    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (accept_mem) begin
                base_q  <= bus.mem_addr;
                wdata_q <= bus.mem_wdata;
                n_q     <= size_bytes(bus.mem_size);
                rbuf_q  <= '0;
            end else if (accept_if) begin
                base_q  <= bus.if_addr;
                n_q     <= 3'd4;
                rbuf_q  <= '0;
            end else if (capture) begin
                rbuf_q  <= rd_word;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= ST_IDLE;
            iss_cnt       <= 3'd0;
            rcv_cnt       <= 3'd0;
            wr_q          <= 1'b0;
            bus.ram_a     <= '0;
            bus.ram_dout  <= 8'h00;
            bus.if_done   <= 1'b0;
            bus.mem_done  <= 1'b0;
            bus.if_inst   <= '0;
            bus.mem_rdata <= '0;
        end else if (rdy_in) begin
            bus.if_done  <= 1'b0;
            bus.mem_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_mem) begin
                        state        <= bus.mem_we ? ST_MEM_WR : ST_MEM_RD;
                        wr_q         <= bus.mem_we;
                        bus.ram_a    <= bus.mem_addr;
                        bus.ram_dout <= bus.mem_wdata[7:0];
                        iss_cnt      <= 3'd1;
                        rcv_cnt      <= 3'd0;
                    end else if (accept_if) begin
                        state        <= ST_IF_RD;
                        bus.ram_a    <= bus.if_addr;
                        iss_cnt      <= 3'd1;
                        rcv_cnt      <= 3'd0;
                    end
                end
                ST_IF_RD, ST_MEM_RD: begin
                    if (flush_rd) begin
                        state   <= ST_IDLE;
                        iss_cnt <= 3'd0;
                        rcv_cnt <= 3'd0;
                    end else begin
                        // ram_a stays on the last byte once all n are issued: no over-fetch.
                        if (iss_cnt < n_q) begin
                            bus.ram_a <= base_q + ADDR_W'(iss_cnt);
                        end
                        iss_cnt <= iss_cnt + 3'd1;
                        if (capture) begin
                            rcv_cnt <= rcv_cnt + 3'd1;
                            if (last_rcv) begin
                                state   <= ST_IDLE;
                                iss_cnt <= 3'd0;
                                rcv_cnt <= 3'd0;
                                if (state == ST_IF_RD) begin
                                    bus.if_inst <= rd_word[INST_LEN-1:0];
                                    bus.if_done <= 1'b1;
                                end else begin
                                    bus.mem_rdata <= rd_word;
                                    bus.mem_done  <= 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_MEM_WR: begin
                    if (iss_cnt < n_q) begin
                        bus.ram_a    <= base_q + ADDR_W'(iss_cnt);
                        bus.ram_dout <= wdata_q[8*iss_cnt[1:0] +: 8];
                        iss_cnt      <= iss_cnt + 3'd1;
                    end else begin
                        state        <= ST_IDLE;
                        wr_q         <= 1'b0;
                        iss_cnt      <= 3'd0;
                        bus.mem_done <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    wr_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM/IO model, transaction-level expectation tables
// indexed by active cycle, a per-cycle compare process and directed scenarios.
module tb_mem_ctrl;

    localparam int TMAX = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    always #5 clk = ~clk;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus.slave)
    );

    logic [7:0]  ram [0:262143];
    logic [7:0]  io_byte;
    int          t = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    bit          exp_if_done  [TMAX];
    bit          exp_mem_done [TMAX];
    bit          exp_wr       [TMAX];
    bit          exp_a_chk    [TMAX];
    logic [31:0] exp_a        [TMAX];
    logic [7:0]  exp_dout     [TMAX];
    logic [31:0] exp_if_inst  [TMAX];
    logic [31:0] exp_mem_rdata[TMAX];
    int          first_if, first_mem, n_if_done;
    int          t0;

    // RAM/IO device shares the core's ready: it freezes with the controller.
    always @(posedge clk) begin
        if (bus.ram_wr) ram[bus.ram_a[17:0]] <= bus.ram_dout;
        if (rdy) bus.ram_din <= (bus.ram_a == 32'h0003_0000) ? io_byte : ram[bus.ram_a[17:0]];
    end

    // Logical cycle count: advances only on edges the controller acts on.
    always @(posedge clk) if (!rst && rdy) t <= t + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0d, time=%0t)", name, act, exp, t, $time);
        end
    endtask

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        return (a == 32'h0003_0000) ? io_byte : ram[a[17:0]];
    endfunction

    task automatic hold_from(input bit is_if, input int from, input logic [31:0] v);
        for (int i = from; i < TMAX; i++) begin
            if (is_if) exp_if_inst[i] = v;
            else       exp_mem_rdata[i] = v;
        end
    endtask

    task automatic model_reset(input int from);
        for (int i = from; i < TMAX; i++) begin
            exp_if_done[i] = 0; exp_mem_done[i] = 0; exp_wr[i] = 0; exp_a_chk[i] = 0;
            exp_if_inst[i] = '0; exp_mem_rdata[i] = '0;
        end
    endtask

    // Read of n bytes sampled at logical cycle s; cut = cycle of abandonment (flush).
    task automatic plan_read(input bit is_if, input int s, input logic [31:0] addr,
                             input int n, input int cut);
        logic [31:0] v;
        logic [31:0] a;
        v = '0;
        for (int k = 0; k < n; k++) begin
            a = addr + k;
            if (1 + k <= cut) begin
                exp_a_chk[s+1+k] = 1;
                exp_a[s+1+k]     = a;
            end
            v[8*k +: 8] = ram_byte(a);
        end
        if (cut >= n + 2) begin
            if (is_if) exp_if_done[s+n+2] = 1;
            else       exp_mem_done[s+n+2] = 1;
            hold_from(is_if, s + n + 2, v);
        end
    endtask

    task automatic plan_write(input int s, input logic [31:0] addr, input int n,
                              input logic [31:0] wdata);
        for (int k = 0; k < n; k++) begin
            exp_a_chk[s+1+k] = 1;
            exp_a[s+1+k]     = addr + k;
            exp_wr[s+1+k]    = 1;
            exp_dout[s+1+k]  = wdata[8*k +: 8];
        end
        exp_mem_done[s+n+1] = 1;
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst && t < TMAX) begin
            chk("if_done",   32'(bus.if_done),  32'(exp_if_done[t]));
            chk("mem_done",  32'(bus.mem_done), 32'(exp_mem_done[t]));
            chk("ram_wr",    32'(bus.ram_wr),   32'(exp_wr[t] & rdy));
            if (exp_a_chk[t]) chk("ram_a", bus.ram_a, exp_a[t]);
            if (exp_wr[t] && rdy) chk("ram_dout", 32'(bus.ram_dout), 32'(exp_dout[t]));
            chk("if_inst",   bus.if_inst,   exp_if_inst[t]);
            chk("mem_rdata", bus.mem_rdata, exp_mem_rdata[t]);
        end
    end

    // Ends cycle c; requesters drop req on the edge where they see done.
    task automatic tick(input int c);
        bit saw_if, saw_mem;
        @(negedge clk);
        saw_if  = bus.if_done;
        saw_mem = bus.mem_done;
        if (saw_if) begin
            n_if_done++;
            if (first_if < 0) first_if = c;
        end
        if (saw_mem && first_mem < 0) first_mem = c;
        @(posedge clk);
        #1;
        if (saw_if)  bus.if_req  = 1'b0;
        if (saw_mem) bus.mem_req = 1'b0;
    endtask

    task automatic new_test();
        first_if  = -1;
        first_mem = -1;
        n_if_done = 0;
        t0 = t;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ram_wr"},    32'(bus.ram_wr),   32'h0);
        chk({tag, "_ram_a"},     bus.ram_a,         32'h0);
        chk({tag, "_ram_dout"},  32'(bus.ram_dout), 32'h0);
        chk({tag, "_if_done"},   32'(bus.if_done),  32'h0);
        chk({tag, "_mem_done"},  32'(bus.mem_done), 32'h0);
        chk({tag, "_if_inst"},   bus.if_inst,       32'h0);
        chk({tag, "_mem_rdata"}, bus.mem_rdata,     32'h0);
    endtask

    initial begin
        int bad;
        bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
        bus.mem_req = 0; bus.mem_we = 0; bus.mem_size = 2'b00; bus.mem_addr = '0; bus.mem_wdata = '0;
        io_byte = 8'h41;
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        {ram[32'h103], ram[32'h102], ram[32'h101], ram[32'h100]} = 32'h0000_0513;
        {ram[32'h003], ram[32'h002], ram[32'h001], ram[32'h000]} = 32'h0000_0137;
        {ram[32'h011], ram[32'h010]} = 16'hABCD;
        {ram[32'h403], ram[32'h402], ram[32'h401], ram[32'h400]} = 32'h4433_2211;
        {ram[32'h503], ram[32'h502], ram[32'h501], ram[32'h500]} = 32'h9988_7766;
        model_reset(0);

        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk_en = 1'b1;

        // 1: plain IF word read
        new_test();
        bus.if_req = 1; bus.if_addr = 32'h100;
        plan_read(1, t0, 32'h100, 4, 99);
        for (int c = 0; c < 10; c++) tick(c);
        chk("t1_if_done_cycle", first_if, 6);
        chk("t1_if_inst", bus.if_inst, 32'h0000_0513);

        // 2: MEM store wins over a simultaneous IF fetch
        new_test();
        bus.if_req = 1; bus.if_addr = 32'h0;
        bus.mem_req = 1; bus.mem_we = 1; bus.mem_size = 2'b10;
        bus.mem_addr = 32'h200; bus.mem_wdata = 32'hDEAD_BEEF;
        plan_write(t0, 32'h200, 4, 32'hDEAD_BEEF);
        plan_read(1, t0 + 6, 32'h0, 4, 99);
        for (int c = 0; c < 15; c++) tick(c);
        chk("t2_mem_done_cycle", first_mem, 5);
        chk("t2_if_done_cycle", first_if, 12);
        chk("t2_ram_word", {ram[32'h203], ram[32'h202], ram[32'h201], ram[32'h200]}, 32'hDEAD_BEEF);
        chk("t2_if_inst", bus.if_inst, 32'h0000_0137);

        // 3: single-byte IO load touches only 0x30000
        new_test();
        bus.mem_req = 1; bus.mem_we = 0; bus.mem_size = 2'b00; bus.mem_addr = 32'h0003_0000;
        plan_read(0, t0, 32'h0003_0000, 1, 99);
        bad = 0;
        for (int c = 0; c < 7; c++) begin
            if (c >= 1 && c <= 3 && bus.ram_a !== 32'h0003_0000) bad++;
            tick(c);
        end
        chk("t3_other_addr_cycles", bad, 0);
        chk("t3_mem_done_cycle", first_mem, 3);
        chk("t3_mem_rdata", bus.mem_rdata, 32'h0000_0041);

        // 4: flush an IF read while a half load waits
        new_test();
        bus.if_req = 1; bus.if_addr = 32'h500;
        plan_read(1, t0, 32'h500, 4, 3);
        plan_read(0, t0 + 4, 32'h10, 2, 99);
        for (int c = 0; c < 12; c++) begin
            if (c == 1) begin
                bus.mem_req = 1; bus.mem_we = 0; bus.mem_size = 2'b01; bus.mem_addr = 32'h10;
            end
            if (c == 3) bus.if_flush = 1;
            if (c == 4) begin bus.if_flush = 0; bus.if_req = 0; end
            tick(c);
        end
        chk("t4_if_done_count", n_if_done, 0);
        chk("t4_mem_done_cycle", first_mem, 8);
        chk("t4_mem_rdata", bus.mem_rdata, 32'h0000_ABCD);

        // 5: ready low for three cycles in a word load
        new_test();
        bus.mem_req = 1; bus.mem_we = 0; bus.mem_size = 2'b10; bus.mem_addr = 32'h400;
        plan_read(0, t0, 32'h400, 4, 99);
        for (int c = 0; c < 13; c++) begin
            if (c == 3) rdy = 1'b0;
            if (c == 6) rdy = 1'b1;
            tick(c);
        end
        chk("t5_mem_done_cycle", first_mem, 9);
        chk("t5_mem_rdata", bus.mem_rdata, 32'h4433_2211);

        // 6: reset during a word store
        new_test();
        bus.mem_req = 1; bus.mem_we = 1; bus.mem_size = 2'b10;
        bus.mem_addr = 32'h600; bus.mem_wdata = 32'hCAFE_F00D;
        plan_write(t0, 32'h600, 4, 32'hCAFE_F00D);
        tick(0);
        tick(1);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("t6_async");
        model_reset(t);
        bus.mem_req = 0; bus.mem_we = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("t6_ram_after_abort", {ram[32'h603], ram[32'h602], ram[32'h601], ram[32'h600]}, 32'h0000_000D);
        @(posedge clk);
        #1;
        new_test();
        bus.if_req = 1; bus.if_addr = 32'h100;
        plan_read(1, t0, 32'h100, 4, 99);
        for (int c = 0; c < 10; c++) tick(c);
        chk("t6_if_done_cycle", first_if, 6);
        chk("t6_if_inst", bus.if_inst, 32'h0000_0513);

        // 7: half store wrapping past the top of the address space
        new_test();
        bus.mem_req = 1; bus.mem_we = 1; bus.mem_size = 2'b01;
        bus.mem_addr = 32'hFFFF_FFFF; bus.mem_wdata = 32'h0000_BEEF;
        plan_write(t0, 32'hFFFF_FFFF, 2, 32'h0000_BEEF);
        for (int c = 0; c < 7; c++) tick(c);
        chk("t7_mem_done_cycle", first_mem, 3);
        chk("t7_ram_top", 32'(ram[18'h3FFFF]), 32'h0000_00EF);
        chk("t7_ram_zero", 32'(ram[18'h00000]), 32'h0000_00BE);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
